// File: rtl/cpu16_pkg.sv
// ---------------------------------------------------------------------------
// cpu16_pkg
//  Shared sizes and types for the 16-bit single-cycle CPU datapath.
//  DATA_W   : register / datapath width
//  REG_AW   : register index width
//  NUM_REGS : number of architectural registers
// ---------------------------------------------------------------------------
package cpu16_pkg;

    localparam int DATA_W   = 16;
    localparam int REG_AW   = 3;
    localparam int NUM_REGS = 8;

    typedef logic [REG_AW-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/mux16_8_1.sv
// ---------------------------------------------------------------------------
// mux16_8_1
//  W-bit 8:1 multiplexer used for every register-file read port.
//  Ports:
//    i0..i7 : in  W  data inputs
//    sel    : in  3  input select (register index)
//    y      : out W  selected input (combinational)
// ---------------------------------------------------------------------------
module mux16_8_1
    import cpu16_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] i0,
    input  logic [W-1:0] i1,
    input  logic [W-1:0] i2,
    input  logic [W-1:0] i3,
    input  logic [W-1:0] i4,
    input  logic [W-1:0] i5,
    input  logic [W-1:0] i6,
    input  logic [W-1:0] i7,
    input  reg_idx_t     sel,
    output logic [W-1:0] y
);

    always_comb begin
        case (sel)
            3'd0:    y = i0;
            3'd1:    y = i1;
            3'd2:    y = i2;
            3'd3:    y = i3;
            3'd4:    y = i4;
            3'd5:    y = i5;
            3'd6:    y = i6;
            3'd7:    y = i7;
            // Unknown select propagates as X so a bad index is never hidden.
            default: y = 'x;
        endcase
    end

endmodule

// File: rtl/regfile8x16.sv
// ---------------------------------------------------------------------------
// regfile8x16
//  8 x DATA_W general-purpose register file: one synchronous write port,
//  two combinational read ports (A, B) for the ALU and one combinational
//  debug read port.
//  Ports:
//    clk      : in  1       system clock, rising edge
//    rst      : in  1       synchronous active-high reset, clears all regs
//    we       : in  1       write enable
//    waddr    : in  3       write index
//    wdata    : in  DATA_W  write data
//    raddr_a  : in  3       read index, port A
//    rdata_a  : out DATA_W  read data, port A
//    raddr_b  : in  3       read index, port B
//    rdata_b  : out DATA_W  read data, port B
//    dbg_addr : in  3       debug read index
//    dbg_data : out DATA_W  debug read data (storage only, never forwarded)
//  Parameters:
//    DATA_W   : register width
//    R0_ZERO  : 1 -> r0 is hard-wired to zero and writes to it are dropped
//  Build option:
//    REGFILE_BYPASS_EN : when defined, a write in progress is forwarded to
//                        ports A and B in the same cycle.
// ---------------------------------------------------------------------------
module regfile8x16
    import cpu16_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter bit R0_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  reg_idx_t          waddr,
    input  logic [DATA_W-1:0] wdata,
    input  reg_idx_t          raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  reg_idx_t          raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  reg_idx_t          dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] wr_sel;

    // One-hot write decode. The r0 slot is suppressed when r0 is hard zero,
    // so its storage stays at the reset value forever.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_wdec
            if (R0_ZERO && gi == 0) begin : g_r0_const
                assign wr_sel[gi] = 1'b0;
            end else begin : g_wr
                assign wr_sel[gi] = we & ~rst & (waddr == REG_AW'(gi));
            end
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_sel[i]) begin
                regs_d[i] = wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Raw storage reads; zeroing and forwarding are applied after the muxes.
    logic [DATA_W-1:0] mux_a_y;
    logic [DATA_W-1:0] mux_b_y;
    logic [DATA_W-1:0] mux_dbg_y;

    mux16_8_1 #(.W(DATA_W)) u_mux_a (
        .i0(regs_q[0]), .i1(regs_q[1]), .i2(regs_q[2]), .i3(regs_q[3]),
        .i4(regs_q[4]), .i5(regs_q[5]), .i6(regs_q[6]), .i7(regs_q[7]),
        .sel(raddr_a), .y(mux_a_y)
    );

    mux16_8_1 #(.W(DATA_W)) u_mux_b (
        .i0(regs_q[0]), .i1(regs_q[1]), .i2(regs_q[2]), .i3(regs_q[3]),
        .i4(regs_q[4]), .i5(regs_q[5]), .i6(regs_q[6]), .i7(regs_q[7]),
        .sel(raddr_b), .y(mux_b_y)
    );

    mux16_8_1 #(.W(DATA_W)) u_mux_dbg (
        .i0(regs_q[0]), .i1(regs_q[1]), .i2(regs_q[2]), .i3(regs_q[3]),
        .i4(regs_q[4]), .i5(regs_q[5]), .i6(regs_q[6]), .i7(regs_q[7]),
        .sel(dbg_addr), .y(mux_dbg_y)
    );

    logic fwd_a;
    logic fwd_b;

`ifdef REGFILE_BYPASS_EN
    // Forward only a write that will actually commit on the coming edge.
    logic wr_live;
    assign wr_live = we & ~rst & ~(R0_ZERO && waddr == '0);
    assign fwd_a   = wr_live & (raddr_a == waddr);
    assign fwd_b   = wr_live & (raddr_b == waddr);
`else
    assign fwd_a = 1'b0;
    assign fwd_b = 1'b0;
`endif

    always_comb begin
        rdata_a = mux_a_y;
        if (R0_ZERO && raddr_a == '0) begin
            rdata_a = '0;
        end
        if (fwd_a) begin
            rdata_a = wdata;
        end
    end

    always_comb begin
        rdata_b = mux_b_y;
        if (R0_ZERO && raddr_b == '0) begin
            rdata_b = '0;
        end
        if (fwd_b) begin
            rdata_b = wdata;
        end
    end

    always_comb begin
        dbg_data = mux_dbg_y;
        if (R0_ZERO && dbg_addr == '0) begin
            dbg_data = '0;
        end
    end

endmodule

// File: tb/tb_regfile8x16.sv
// ---------------------------------------------------------------------------
// tb_regfile8x16
//  Directed, table-driven bench for regfile8x16. Two instances share all
//  inputs: dut (r0 hard zero) and dut_r0 (r0 ordinary register).
// ---------------------------------------------------------------------------
module tb_regfile8x16;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic [2:0]  raddr_a;
    logic [2:0]  raddr_b;
    logic [2:0]  dbg_addr;
    logic [15:0] rdata_a,  rdata_b,  dbg_data;
    logic [15:0] rdata_a0, rdata_b0, dbg_data0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    regfile8x16 #(.DATA_W(16), .R0_ZERO(1'b1)) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rdata_a),
        .raddr_b(raddr_b), .rdata_b(rdata_b),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    regfile8x16 #(.DATA_W(16), .R0_ZERO(1'b0)) dut_r0 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rdata_a0),
        .raddr_b(raddr_b), .rdata_b(rdata_b0),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data0)
    );

    typedef struct {
        logic        we;
        logic [2:0]  waddr;
        logic [15:0] wdata;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic [2:0]  rd;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
        logic [15:0] exp_d;
    } vec_t;

    vec_t vecs [15];

    // Bench-side expected register contents for each instance.
    logic [15:0] model1 [8];
    logic [15:0] model0 [8];

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; we = 1'b0; waddr = 3'd0; wdata = 16'h0000;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        we = 1'b1; waddr = a; wdata = d;
        tick();
        we = 1'b0;
    endtask

    // Read every index on all ports of both instances and compare with models.
    task automatic sweep(input string tag);
        for (int i = 0; i < 8; i++) begin
            raddr_a = 3'(i); raddr_b = 3'(7 - i); dbg_addr = 3'(i);
            #1;
            chk($sformatf("%s a[%0d]", tag, i), rdata_a, model1[i]);
            chk($sformatf("%s b[%0d]", tag, 7 - i), rdata_b, model1[7 - i]);
            chk($sformatf("%s dbg[%0d]", tag, i), dbg_data, model1[i]);
            chk($sformatf("%s r0inst a[%0d]", tag, i), rdata_a0, model0[i]);
            $display("sweep %s idx=%0d a=%h b=%h dbg=%h a0=%h", tag, i, rdata_a, rdata_b, dbg_data, rdata_a0);
        end
    endtask

    task automatic clear_models();
        for (int i = 0; i < 8; i++) begin
            model1[i] = 16'h0000;
            model0[i] = 16'h0000;
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] vals [8];
        logic [15:0] exp_raw;
        vals[0] = 16'd0;  vals[1] = 16'd29; vals[2] = 16'd38; vals[3] = 16'd51;
        vals[4] = 16'd64; vals[5] = 16'd82; vals[6] = 16'd94; vals[7] = 16'd112;

        // Table: 7 writes (reads probe the previously written register and
        // the debug port probes the target, which must still be old), then
        // a full read sweep with we=0.
        for (int k = 1; k < 8; k++) begin
            vecs[k-1] = '{we: 1'b1, waddr: 3'(k), wdata: vals[k],
                          ra: 3'(k-1), rb: 3'(k-1), rd: 3'(k),
                          exp_a: vals[k-1], exp_b: vals[k-1], exp_d: 16'h0000};
        end
        for (int i = 0; i < 8; i++) begin
            vecs[7+i] = '{we: 1'b0, waddr: 3'd0, wdata: 16'hFFFF,
                          ra: 3'(i), rb: 3'(7-i), rd: 3'(i),
                          exp_a: vals[i], exp_b: vals[7-i], exp_d: vals[i]};
        end

        idle();
        raddr_a = 3'd0; raddr_b = 3'd0; dbg_addr = 3'd0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        clear_models();
        sweep("por");

        // 1. Reset overrides a pending write and clears preloaded data.
        wr(3'd3, 16'h1111);
        wr(3'd1, 16'h0005);
        rst = 1'b1; we = 1'b1; waddr = 3'd3; wdata = 16'hBEEF;
        tick();
        idle();
        sweep("rst");

        // 2. Table-driven write then read-all.
        for (int v = 0; v < 15; v++) begin
            we = vecs[v].we; waddr = vecs[v].waddr; wdata = vecs[v].wdata;
            raddr_a = vecs[v].ra; raddr_b = vecs[v].rb; dbg_addr = vecs[v].rd;
            #1;
            $display("vec %0d we=%b wa=%0d wd=%h ra=%0d rb=%0d rd=%0d -> a=%h b=%h dbg=%h",
                     v, we, waddr, wdata, raddr_a, raddr_b, dbg_addr, rdata_a, rdata_b, dbg_data);
            chk($sformatf("vec%0d a", v), rdata_a, vecs[v].exp_a);
            chk($sformatf("vec%0d b", v), rdata_b, vecs[v].exp_b);
            chk($sformatf("vec%0d dbg", v), dbg_data, vecs[v].exp_d);
            tick();
        end
        idle();
        for (int i = 0; i < 8; i++) begin
            model1[i] = vals[i];
            model0[i] = vals[i];
        end

        // 3. r0 protection: dropped with R0_ZERO=1, stored with R0_ZERO=0.
        raddr_a = 3'd0;
        we = 1'b1; waddr = 3'd0; wdata = 16'h1234;
        #1;
        chk("r0 write cycle a", rdata_a, 16'h0000);
        tick();
        idle();
        #1;
        chk("r0 after a", rdata_a, 16'h0000);
        chk("r0 after a (r0 ordinary)", rdata_a0, 16'h1234);
        $display("r0 write: a=%h a0=%h", rdata_a, rdata_a0);
        model0[0] = 16'h1234;

        // 4. Same-cycle read-after-write on r5 (holds 82).
        we = 1'b1; waddr = 3'd5; wdata = 16'h00AA;
        raddr_a = 3'd5; raddr_b = 3'd5; dbg_addr = 3'd5;
        #1;
        exp_raw = BYP ? 16'h00AA : 16'd82;
        chk("raw pre a", rdata_a, exp_raw);
        chk("raw pre b", rdata_b, exp_raw);
        chk("raw pre dbg", dbg_data, 16'd82);
        $display("raw pre: a=%h b=%h dbg=%h", rdata_a, rdata_b, dbg_data);
        tick();
        idle();
        #1;
        chk("raw post a", rdata_a, 16'h00AA);
        chk("raw post b", rdata_b, 16'h00AA);
        chk("raw post dbg", dbg_data, 16'h00AA);
        $display("raw post: a=%h b=%h dbg=%h", rdata_a, rdata_b, dbg_data);
        model1[5] = 16'h00AA;
        model0[5] = 16'h00AA;

        // 5. Hold: we=0 while wdata and waddr toggle.
        for (int c = 0; c < 10; c++) begin
            we = 1'b0; waddr = 3'(c); wdata = (c % 2 == 0) ? 16'hFFFF : 16'h5A5A;
            raddr_a = 3'(c % 8); raddr_b = 3'((c + 3) % 8); dbg_addr = 3'((c + 5) % 8);
            tick();
            chk($sformatf("hold%0d a", c), rdata_a, model1[c % 8]);
            chk($sformatf("hold%0d b", c), rdata_b, model1[(c + 3) % 8]);
            $display("hold %0d a=%h b=%h", c, rdata_a, rdata_b);
        end
        idle();
        sweep("hold");

        // 6. Mid-stream reset on the r4 write edge.
        wr(3'd2, 16'h0202);
        wr(3'd3, 16'h0303);
        rst = 1'b1;
        wr(3'd4, 16'h0404);
        rst = 1'b0;
        wr(3'd5, 16'h0505);
        wr(3'd6, 16'h0606);
        idle();
        clear_models();
        model1[5] = 16'h0505; model1[6] = 16'h0606;
        model0[5] = 16'h0505; model0[6] = 16'h0606;
        sweep("mid");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
